tx_frame_sequencer: RTL and testbench

// - Timing and frame controller for the 16-QAM TX chain: LFSR -> mapper -> upsampler_4 -> srrc_prac_tx_flt.
// - Generates the sample and symbol clock enables and the phase count.
// - Sequences each burst as RAMP zeros, PREAMBLE, PAYLOAD (LFSR symbols), then FLUSH zeros, which drains the filter.
// - Drives the symbol-source select, the LFSR advance and the status flags for the chain.

---
 rtl/tx_frame_sequencer_pkg.sv | 20 ++
 rtl/tx_enable_divider.sv | 33 +++
 rtl/tx_frame_sequencer.sv | 143 ++++++++++++++
 tb/tb_tx_frame_sequencer.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_sequencer_pkg.sv
// Shared types and codes for the 16-QAM TX frame sequencer.
// Holds the state encoding, the symbol-source select codes and the divider defaults.
package tx_frame_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_PRE   = 3'd2,
        ST_PAY   = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    localparam logic [1:0] SEL_ZERO = 2'b00;
    localparam logic [1:0] SEL_PRE  = 2'b01;
    localparam logic [1:0] SEL_LFSR = 2'b10;

    localparam int DEF_SPS     = 4;
    localparam int DEF_SYM_DIV = 16;

endpackage

// File: rtl/tx_enable_divider.sv
// Free-running clock divider producing the sample/symbol enables and the phase count.
// Enables are decoded straight from the registered count, so they carry no extra latency.
module tx_enable_divider
    import tx_frame_sequencer_pkg::*;
#(
    parameter int SPS     = DEF_SPS,
    parameter int SYM_DIV = DEF_SYM_DIV
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       samp_en,
    output logic       sym_en,
    output logic [3:0] phase
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (cnt == 4'(SYM_DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 4'd1;
        end
    end

    // SPS is a power of two, so the modulo reduces to a mask.
    assign samp_en = ((cnt & 4'(SPS - 1)) == 4'(SPS - 1));
    assign sym_en  = (cnt == 4'(SYM_DIV - 1));
    assign phase   = cnt;

endmodule

// File: rtl/tx_frame_sequencer.sv
// Burst sequencer for the TX chain: RAMP zeros, PREAMBLE, PAYLOAD, FLUSH zeros.
// All state changes land on sym_en so every output holds steady for a whole symbol.
module tx_frame_sequencer
    import tx_frame_sequencer_pkg::*;
#(
    parameter int SPS       = DEF_SPS,
    parameter int SYM_DIV   = DEF_SYM_DIV,
    parameter int RAMP_LEN  = 4,
    parameter int PRE_LEN   = 8,
    parameter int FLUSH_LEN = 6,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] payload_len,
    output logic             samp_en,
    output logic             sym_en,
    output logic [3:0]       phase,
    output logic             lfsr_en,
    output logic [1:0]       sym_sel,
    output logic [3:0]       pre_sym,
    output logic [LEN_W-1:0] sym_index,
    output logic             busy,
    output logic             done,
    output state_t           state
);

    logic [LEN_W-1:0] len;
    logic             pending;
    logic             abort_flag;
    logic             active;
    logic             to_flush;

    tx_enable_divider #(
        .SPS     (SPS),
        .SYM_DIV (SYM_DIV)
    ) u_div (
        .clk     (clk),
        .reset_n (reset_n),
        .samp_en (samp_en),
        .sym_en  (sym_en),
        .phase   (phase)
    );

    assign active  = (state == ST_RAMP) || (state == ST_PRE) || (state == ST_PAY);
    assign lfsr_en = sym_en && (state == ST_PAY);

    // A requested abort and a natural end share this one path, so FLUSH is entered once.
    always_comb begin
        to_flush = 1'b0;
        if (sym_en) begin
            if (active && abort_flag) begin
                to_flush = 1'b1;
            end else if (state == ST_PRE && sym_index == LEN_W'(PRE_LEN - 1) && len == '0) begin
                to_flush = 1'b1;
            end else if (state == ST_PAY && sym_index == len - LEN_W'(1)) begin
                to_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            sym_sel    <= SEL_ZERO;
            pre_sym    <= 4'h0;
            sym_index  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            len        <= '0;
            pending    <= 1'b0;
            abort_flag <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE && start) begin
                pending <= 1'b1;
                len     <= payload_len;
            end
            if (active && abort) begin
                abort_flag <= 1'b1;
            end
            if (to_flush) begin
                state      <= ST_FLUSH;
                sym_index  <= '0;
                sym_sel    <= SEL_ZERO;
                pre_sym    <= 4'h0;
                abort_flag <= 1'b0;
            end else if (sym_en) begin
                unique case (state)
                    ST_IDLE: begin
                        if (pending) begin
                            state     <= ST_RAMP;
                            pending   <= 1'b0;
                            busy      <= 1'b1;
                            sym_index <= '0;
                        end
                    end
                    ST_RAMP: begin
                        if (sym_index == LEN_W'(RAMP_LEN - 1)) begin
                            state     <= ST_PRE;
                            sym_index <= '0;
                            sym_sel   <= SEL_PRE;
                            pre_sym   <= 4'h0;
                        end else begin
                            sym_index <= sym_index + LEN_W'(1);
                        end
                    end
                    ST_PRE: begin
                        if (sym_index == LEN_W'(PRE_LEN - 1)) begin
                            state     <= ST_PAY;
                            sym_index <= '0;
                            sym_sel   <= SEL_LFSR;
                            pre_sym   <= 4'h0;
                        end else begin
                            sym_index <= sym_index + LEN_W'(1);
                            pre_sym   <= sym_index[0] ? 4'h0 : 4'hF;
                        end
                    end
                    ST_PAY: begin
                        sym_index <= sym_index + LEN_W'(1);
                    end
                    ST_FLUSH: begin
                        if (sym_index == LEN_W'(FLUSH_LEN - 1)) begin
                            state     <= ST_IDLE;
                            sym_index <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            sym_index <= sym_index + LEN_W'(1);
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_frame_sequencer.sv
// Self-checking bench for tx_frame_sequencer against a symbol-plan reference model.
// Each burst is modelled as a queue of planned symbols that is consumed one per symbol period.
module tb_tx_frame_sequencer;
    import tx_frame_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] payload_len = '0;
    logic        samp_en, sym_en, lfsr_en, busy, done;
    logic [3:0]  phase, pre_sym;
    logic [1:0]  sym_sel;
    logic [15:0] sym_index;
    state_t      dut_state;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    tx_frame_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .abort       (abort),
        .payload_len (payload_len),
        .samp_en     (samp_en),
        .sym_en      (sym_en),
        .phase       (phase),
        .lfsr_en     (lfsr_en),
        .sym_sel     (sym_sel),
        .pre_sym     (pre_sym),
        .sym_index   (sym_index),
        .busy        (busy),
        .done        (done),
        .state       (dut_state)
    );

    // Reference model: kind 0 idle, 1 ramp, 2 preamble, 3 payload, 4 flush.
    typedef struct {
        int kind;
        int idx;
    } item_t;

    item_t       plan_q[$];
    int          m_cnt, m_kind, m_idx;
    bit          m_ps, m_ab, m_done;
    logic [15:0] m_len;

    function automatic void model_reset();
        plan_q.delete();
        m_cnt = 0; m_kind = 0; m_idx = 0;
        m_ps = 0; m_ab = 0; m_done = 0; m_len = '0;
    endfunction

    function automatic void build_plan(int len);
        item_t it;
        for (int i = 0; i < 4; i++) begin it.kind = 1; it.idx = i; plan_q.push_back(it); end
        for (int i = 0; i < 8; i++) begin it.kind = 2; it.idx = i; plan_q.push_back(it); end
        for (int i = 0; i < len; i++) begin it.kind = 3; it.idx = i; plan_q.push_back(it); end
        for (int i = 0; i < 6; i++) begin it.kind = 4; it.idx = i; plan_q.push_back(it); end
    endfunction

    function automatic void model_edge();
        bit    boundary, was_active, old_ps;
        item_t it;
        if (!reset_n) begin
            model_reset();
            return;
        end
        boundary   = (m_cnt == 15);
        was_active = (m_kind >= 1 && m_kind <= 3);
        old_ps     = m_ps;
        m_done     = 0;
        if (m_kind == 0 && start) begin
            m_ps  = 1;
            m_len = payload_len;
        end
        if (boundary) begin
            if (m_kind == 0) begin
                if (old_ps) begin
                    build_plan(int'(m_len));
                    it = plan_q.pop_front();
                    m_kind = it.kind; m_idx = it.idx;
                    m_ps = 0;
                end
            end else begin
                if (m_ab) begin
                    while (plan_q.size() > 0 && plan_q[0].kind != 4) void'(plan_q.pop_front());
                end
                m_ab = 0;
                if (plan_q.size() == 0) begin
                    m_kind = 0; m_idx = 0; m_done = 1;
                end else begin
                    it = plan_q.pop_front();
                    m_kind = it.kind; m_idx = it.idx;
                end
            end
        end
        if (abort && was_active && m_kind >= 1 && m_kind <= 3) m_ab = 1;
        m_cnt = (m_cnt + 1) % 16;
    endfunction

    function automatic logic [33:0] exp_vec();
        logic [1:0] sel;
        logic [3:0] pre;
        sel = (m_kind == 2) ? 2'b01 : (m_kind == 3) ? 2'b10 : 2'b00;
        pre = (m_kind == 2 && (m_idx % 2) == 1) ? 4'hF : 4'h0;
        return {3'(m_kind), ((m_cnt % 4) == 3), (m_cnt == 15), 4'(m_cnt),
                (m_cnt == 15 && m_kind == 3), sel, pre, 16'(m_idx), (m_kind != 0), m_done};
    endfunction

    function automatic logic [33:0] obs_vec();
        return {dut_state, samp_en, sym_en, phase, lfsr_en, sym_sel, pre_sym, sym_index, busy, done};
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        int n_sym, n_samp, n_lfsr, n_busy;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (obs_vec() !== 34'd0) begin
            miscompares++;
            $display("FAIL reset_outputs obs=%h exp=%h", obs_vec(), 34'd0);
        end
        repeat (3) step();
        reset_n = 1'b1;
        model_reset();
        n_sym = 0; n_samp = 0; n_lfsr = 0; n_busy = 0;
        for (int c = 0; c < 64; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL idle_cycle obs=%h exp=%h", obs_vec(), exp_vec());
            end
            n_sym += int'(sym_en); n_samp += int'(samp_en);
            n_lfsr += int'(lfsr_en); n_busy += int'(busy);
        end
        vectors++;
        if (n_sym != 4 || n_samp != 16 || n_lfsr != 0 || n_busy != 0) begin
            miscompares++;
            $display("FAIL idle_counts sym=%0d samp=%0d lfsr=%0d busy=%0d exp 4 16 0 0",
                     n_sym, n_samp, n_lfsr, n_busy);
        end
    endtask

    task automatic test_burst(input int len);
        int       n_lfsr, n_busy, n_done;
        bit       fin;
        logic [1:0] prev_sel;
        logic [3:0] pre_list[$];
        repeat ($urandom_range(1, 20)) step();
        start = 1'b1; payload_len = 16'(len);
        step();
        start = 1'b0; payload_len = 16'($urandom_range(200, 900));
        n_lfsr = 0; n_busy = 0; n_done = 0; fin = 0; prev_sel = sym_sel;
        for (int c = 0; c < (len + 30) * 16 && !fin; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL burst_len%0d obs=%h exp=%h", len, obs_vec(), exp_vec());
            end
            vectors++;
            if (sym_sel !== prev_sel && phase !== 4'd0) begin
                miscompares++;
                $display("FAIL sel_stable phase=%0d sel=%0d exp change only at phase 0", phase, sym_sel);
            end
            prev_sel = sym_sel;
            if (sym_sel == 2'b01 && phase == 4'd0) pre_list.push_back(pre_sym);
            n_lfsr += int'(lfsr_en); n_busy += int'(busy); n_done += int'(done);
            fin = done;
        end
        vectors++;
        if (n_lfsr != len || n_done != 1 || n_busy != (18 + len) * 16) begin
            miscompares++;
            $display("FAIL burst_len%0d_counts lfsr=%0d done=%0d busy=%0d exp %0d 1 %0d",
                     len, n_lfsr, n_done, n_busy, len, (18 + len) * 16);
        end
        vectors++;
        if (pre_list.size() != 8) begin
            miscompares++;
            $display("FAIL pre_count got=%0d exp=8", pre_list.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                vectors++;
                if (pre_list[i] !== ((i % 2 == 1) ? 4'hF : 4'h0)) begin
                    miscompares++;
                    $display("FAIL pre_order idx=%0d got=%h exp=%h", i, pre_list[i], (i % 2 == 1) ? 4'hF : 4'h0);
                end
            end
        end
    endtask

    task automatic test_abort(input int len, input int abort_sym);
        int  n_lfsr, n_flush, n_done;
        bit  fin, aborted, pay_seen;
        start = 1'b1; payload_len = 16'(len);
        step();
        start = 1'b0;
        n_lfsr = 0; n_flush = 0; n_done = 0; fin = 0; aborted = 0; pay_seen = 0;
        for (int c = 0; c < 1200 && !fin; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL abort_len%0d obs=%h exp=%h", len, obs_vec(), exp_vec());
            end
            if (sym_sel == 2'b10) pay_seen = 1;
            if (pay_seen && busy && sym_sel == 2'b00) n_flush++;
            n_lfsr += int'(lfsr_en); n_done += int'(done);
            fin = done;
            abort = (!aborted && sym_sel == 2'b10 && int'(sym_index) == abort_sym && phase == 4'd5);
            if (abort) aborted = 1;
        end
        abort = 1'b0;
        vectors++;
        if (n_lfsr != abort_sym + 1 || n_flush != 96 || n_done != 1) begin
            miscompares++;
            $display("FAIL abort_counts lfsr=%0d flush=%0d done=%0d exp %0d 96 1",
                     n_lfsr, n_flush, n_done, abort_sym + 1);
        end
    endtask

    task automatic test_busy_start_and_reset();
        int  n_done, n_busy, n_lfsr;
        bit  fin, hit;
        start = 1'b1; payload_len = 16'd3;
        step();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 400 && !hit; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL pre_reset obs=%h exp=%h", obs_vec(), exp_vec());
            end
            start = (sym_sel == 2'b01 && sym_index == 16'd3 && phase == 4'd5);
            hit = (sym_sel == 2'b01 && sym_index == 16'd5 && phase == 4'd7);
        end
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL reach_pre timeout busy=%0d exp PRE index 5", busy);
        end
        start = 1'b0;
        reset_n = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (obs_vec() !== 34'd0) begin
            miscompares++;
            $display("FAIL midburst_reset obs=%h exp=%h", obs_vec(), 34'd0);
        end
        repeat (5) step();
        reset_n = 1'b1;
        n_done = 0; n_busy = 0;
        for (int c = 0; c < 48; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL post_reset obs=%h exp=%h", obs_vec(), exp_vec());
            end
            n_done += int'(done); n_busy += int'(busy);
        end
        vectors++;
        if (n_done != 0 || n_busy != 0) begin
            miscompares++;
            $display("FAIL no_second_burst done=%0d busy=%0d exp 0 0", n_done, n_busy);
        end
        start = 1'b1; payload_len = 16'd2;
        step();
        start = 1'b0;
        n_done = 0; n_lfsr = 0; fin = 0;
        for (int c = 0; c < 700 && !fin; c++) begin
            step();
            vectors++;
            if (obs_vec() !== exp_vec()) begin
                miscompares++;
                $display("FAIL fresh_burst obs=%h exp=%h", obs_vec(), exp_vec());
            end
            n_done += int'(done); n_lfsr += int'(lfsr_en);
            fin = done;
        end
        vectors++;
        if (n_done != 1 || n_lfsr != 2) begin
            miscompares++;
            $display("FAIL fresh_burst_counts done=%0d lfsr=%0d exp 1 2", n_done, n_lfsr);
        end
    endtask

    task automatic test_random();
        int  len, n_done;
        bit  fin;
        for (int b = 0; b < 25; b++) begin
            repeat ($urandom_range(0, 40)) begin
                abort = ($urandom_range(0, 7) == 0);
                step();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL rand_idle obs=%h exp=%h", obs_vec(), exp_vec());
                end
            end
            len = $urandom_range(0, 12);
            start = 1'b1; payload_len = 16'(len);
            abort = ($urandom_range(0, 3) == 0);
            n_done = 0; fin = 0;
            for (int c = 0; c < 800 && !fin; c++) begin
                step();
                vectors++;
                if (obs_vec() !== exp_vec()) begin
                    miscompares++;
                    $display("FAIL rand_burst%0d obs=%h exp=%h", b, obs_vec(), exp_vec());
                end
                n_done += int'(done);
                fin = done;
                start = (!fin && c > 0 && $urandom_range(0, 99) == 0) || (c == 0 && 1'b0);
                abort = (!fin && $urandom_range(0, 199) == 0);
            end
            start = 1'b0; abort = 1'b0;
            vectors++;
            if (n_done != 1) begin
                miscompares++;
                $display("FAIL rand_done%0d got=%0d exp=1", b, n_done);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_burst(5);
        test_burst(0);
        test_burst(1);
        test_abort(100, 2);
        test_abort(16'hFFFF, 1);
        test_busy_start_and_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
